// File: rtl/regwb_arbiter.sv
// Register-file writeback arbiter: mem loads > queued ALU results > direct ALU, one write per cycle.
// Latency 1 cycle to rf_we; ALU path backpressured by comb stall, mem path never stalled.

module regwb_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Guards keep count inside [0, DEPTH] even if a caller misbehaves.
  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != FULL) || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module regwb_arbiter #(
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [2:0]    alu_adr,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  input  logic [2:0]    mem_adr,
  input  logic [DW-1:0] mem_data,
  output logic          stall,
  output logic          rf_we,
  output logic [2:0]    rf_adr,
  output logic [DW-1:0] rf_data,
  output logic          rel_valid,
  output logic          rel_mem,
  output logic          ovf_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

  typedef struct packed {
    logic [2:0]    adr;
    logic [DW-1:0] dat;
  } wb_t;

  wb_t           alu_wb;
  wb_t           mem_wb;
  wb_t           head_wb;
  wb_t           win_wb;
  logic [CW-1:0] count;
  logic          empty;
  logic          alu_acc;
  logic          fifo_push;
  logic          fifo_pop;
  logic          win_vld;
  logic          win_mem;

  assign alu_wb = '{adr: alu_adr, dat: alu_data};
  assign mem_wb = '{adr: mem_adr, dat: mem_data};
  assign empty  = (count == '0);

  // A mem return can't be held off, so one free slot must stay in reserve whenever it arrives.
  assign stall     = (count == FULL) || ((count == ALMOST) && mem_valid);
  assign alu_acc   = alu_valid && !stall;
  assign fifo_pop  = !empty && !mem_valid;
  assign fifo_push = alu_acc && (!empty || mem_valid);

  regwb_fifo #(
    .W     ($bits(wb_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (alu_wb),
    .pop      (fifo_pop),
    .head_dat (head_wb),
    .count    (count)
  );

  always_comb begin
    win_vld = 1'b0;
    win_mem = 1'b0;
    win_wb  = alu_wb;
    if (mem_valid) begin
      win_vld = 1'b1;
      win_mem = 1'b1;
      win_wb  = mem_wb;
    end else if (!empty) begin
      win_vld = 1'b1;
      win_wb  = head_wb;
    end else if (alu_acc) begin
      win_vld = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we   <= 1'b0;
      rel_mem <= 1'b0;
      rf_adr  <= '0;
      rf_data <= '0;
      ovf_err <= 1'b0;
    end else begin
      rf_we   <= win_vld;
      rel_mem <= win_vld && win_mem;
      if (win_vld) begin
        rf_adr  <= win_wb.adr;
        rf_data <= win_wb.dat;
      end
      if (alu_valid && stall) ovf_err <= 1'b1;
    end
  end

  assign rel_valid = rf_we;
endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed and constrained-random checks of the writeback arbiter (DW=16, DEPTH=2).
module tb_regwb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic [2:0]  alu_adr, mem_adr;
  logic [15:0] alu_data, mem_data;
  logic        stall, rf_we, rel_valid, rel_mem, ovf_err;
  logic [2:0]  rf_adr;
  logic [15:0] rf_data;

  int n_chk = 0;
  int n_err = 0;

  regwb_arbiter #(.DW(16), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_adr   (alu_adr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_adr   (mem_adr),
    .mem_data  (mem_data),
    .stall     (stall),
    .rf_we     (rf_we),
    .rf_adr    (rf_adr),
    .rf_data   (rf_data),
    .rel_valid (rel_valid),
    .rel_mem   (rel_mem),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [2:0] ma, input logic [15:0] md,
                       input logic av, input logic [2:0] aa, input logic [15:0] ad);
    mem_valid = mv; mem_adr = ma; mem_data = md;
    alu_valid = av; alu_adr = aa; alu_data = ad;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic expect_wr(input string tag, input logic [2:0] a, input logic [15:0] d, input logic m);
    check({tag, "_we"},  rf_we, 1);
    check({tag, "_rel"}, rel_valid, 1);
    check({tag, "_adr"}, rf_adr, a);
    check({tag, "_dat"}, rf_data, d);
    check({tag, "_mem"}, rel_mem, m);
  endtask

  task automatic expect_none(input string tag);
    check({tag, "_we"},  rf_we, 0);
    check({tag, "_rel"}, rel_valid, 0);
  endtask

  logic [18:0] alu_q[$];
  logic [18:0] exp_wb;
  logic        mem_pend;
  logic [2:0]  mem_pa;
  logic [15:0] mem_pd;
  int          n_acc, n_rel;

  initial begin
    reset = 1'b0;
    idle();
    #12;
    check("rst_we", rf_we, 0);
    check("rst_rel", rel_valid, 0);
    check("rst_relmem", rel_mem, 0);
    check("rst_adr", rf_adr, 0);
    check("rst_dat", rf_data, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_stall", stall, 0);
    step();
    reset = 1'b1;

    // Direct ALU write, then idle hold
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
    step(); idle();
    expect_wr("direct", 3'd3, 16'h1234, 1'b0);
    step();
    expect_none("direct_idle");
    check("hold_adr", rf_adr, 3);
    check("hold_dat", rf_data, 16'h1234);

    // Same-cycle mem/ALU conflict
    drive(1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd2, 16'h0002);
    #1 check("conf_stall", stall, 0);
    step(); idle();
    expect_wr("conf_mem", 3'd5, 16'hAAAA, 1'b1);
    step();
    expect_wr("conf_alu", 3'd2, 16'h0002, 1'b0);
    step();
    expect_none("conf_end");

    // Fill: stall with one queued entry while mem keeps arriving
    drive(1'b1, 3'd1, 16'h1111, 1'b1, 3'd4, 16'h4444);
    step();
    drive(1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 16'h0);
    #1 check("fill_stall1", stall, 1);
    expect_wr("fill_m1", 3'd1, 16'h1111, 1'b1);
    step();
    drive(1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 16'h0);
    #1 check("fill_stall2", stall, 1);
    expect_wr("fill_m6", 3'd6, 16'h6666, 1'b1);
    step(); idle();
    #1 check("fill_stall_off", stall, 0);
    expect_wr("fill_m7", 3'd7, 16'h7777, 1'b1);
    step();
    expect_wr("fill_a4", 3'd4, 16'h4444, 1'b0);
    step();
    expect_none("fill_end");

    // ALU ordering through the queue with simultaneous pop/push
    drive(1'b1, 3'd0, 16'h0F0F, 1'b1, 3'd1, 16'h0101);
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h0202);
    #1 check("ord_stall", stall, 0);
    expect_wr("ord_m0", 3'd0, 16'h0F0F, 1'b1);
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h0303);
    expect_wr("ord_a1", 3'd1, 16'h0101, 1'b0);
    step(); idle();
    expect_wr("ord_a2", 3'd2, 16'h0202, 1'b0);
    step();
    expect_wr("ord_a3", 3'd3, 16'h0303, 1'b0);
    step();
    expect_none("ord_end");

    // Overflow: ALU request while stalled is dropped
    drive(1'b1, 3'd5, 16'h5555, 1'b1, 3'd6, 16'h6666);
    step();
    drive(1'b1, 3'd7, 16'h7777, 1'b1, 3'd1, 16'hDEAD);
    #1 check("ovf_stall", stall, 1);
    step(); idle();
    expect_wr("ovf_m7", 3'd7, 16'h7777, 1'b1);
    check("ovf_set", ovf_err, 1);
    step();
    expect_wr("ovf_a6", 3'd6, 16'h6666, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_none("ovf_drop");
    end
    check("ovf_sticky", ovf_err, 1);

    // Reset mid-drain
    drive(1'b1, 3'd2, 16'h2222, 1'b1, 3'd3, 16'h3333);
    step(); idle();
    expect_wr("rd_m2", 3'd2, 16'h2222, 1'b1);
    #2 reset = 1'b0;
    mem_valid = 1'b1;
    #1;
    check("rd_we", rf_we, 0);
    check("rd_rel", rel_valid, 0);
    check("rd_relmem", rel_mem, 0);
    check("rd_adr", rf_adr, 0);
    check("rd_dat", rf_data, 0);
    check("rd_ovf", ovf_err, 0);
    check("rd_stall_cnt0", stall, 0);
    idle();
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_none("rd_post");
    end
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'hBEEF);
    step(); idle();
    expect_wr("rd_new", 3'd4, 16'hBEEF, 1'b0);

    // Constrained random traffic honouring stall
    mem_pend = 1'b0; mem_pa = '0; mem_pd = '0;
    n_acc = 0; n_rel = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      step();
      check("rnd_relv", rel_valid, rf_we);
      if (rf_we) n_rel++;
      if (mem_pend) begin
        expect_wr("rnd_mem", mem_pa, mem_pd, 1'b1);
      end else if (rf_we) begin
        check("rnd_relmem0", rel_mem, 0);
        check("rnd_alu_avail", alu_q.size() > 0, 1);
        if (alu_q.size() > 0) begin
          exp_wb = alu_q.pop_front();
          check("rnd_alu_wb", {rf_adr, rf_data}, exp_wb);
        end
      end
      idle();
      mem_pend = 1'b0;
      if (cyc < 280) begin
        if ($urandom_range(0, 9) < 4) begin
          mem_pa = 3'($urandom_range(0, 7));
          mem_pd = 16'($urandom_range(0, 16'hFFFF));
          mem_valid = 1'b1; mem_adr = mem_pa; mem_data = mem_pd;
          mem_pend = 1'b1;
        end
        #1;
        if (!stall && $urandom_range(0, 1) == 1) begin
          alu_valid = 1'b1;
          alu_adr   = 3'($urandom_range(0, 7));
          alu_data  = 16'($urandom_range(0, 16'hFFFF));
          alu_q.push_back({alu_adr, alu_data});
          n_acc++;
        end
        if (mem_pend) n_acc++;
      end
    end
    check("rnd_q_empty", alu_q.size(), 0);
    check("rnd_count", n_rel, n_acc);
    check("rnd_ovf", ovf_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
